// File: rtl/rcc_reset_sequencer.sv
`default_nettype none
// ============================================================================
// rcc_reset_sequencer : lock-qualified, staggered reset release for the SoC
// Revision 1.0
// ============================================================================
module rcc_reset_sequencer #(
  parameter int NUM_PERIPH       = 6,
  parameter int LOCK_SYNC_STAGES = 2,
  parameter int STABLE_CYCLES    = 256,
  parameter int STAGGER_CYCLES   = 4,
  parameter int SWRST_PULSE      = 16,
  parameter int TIMEOUT_CYCLES   = 65535
) (
  input  logic                  io_ahb_PCLK,
  input  logic                  io_ahb_PRESETn,
  input  logic                  ddr_pll_lock,
  input  logic                  tmds_pll_lock,
  input  logic [NUM_PERIPH-1:0] periph_en,
  input  logic [NUM_PERIPH-1:0] periph_swrst,
  input  logic                  lock_lost_clr,
  output logic                  memory_clk_en,
  output logic                  video_rst,
  output logic [NUM_PERIPH-1:0] periph_rst,
  output logic                  sys_ready,
  output logic                  lock_lost,
  output logic                  pll_fault,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_MEM_EN    = 3'd3,
    ST_RELEASE   = 3'd4,
    ST_RUN       = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  localparam int c_CNT_MAX_A = (TIMEOUT_CYCLES > STABLE_CYCLES) ? TIMEOUT_CYCLES : STABLE_CYCLES;
  localparam int c_CNT_MAX   = (c_CNT_MAX_A > STAGGER_CYCLES) ? c_CNT_MAX_A : STAGGER_CYCLES;
  localparam int c_CNT_W     = $clog2(c_CNT_MAX) + 1;
  localparam int c_IDX_W     = $clog2(NUM_PERIPH) + 1;
  localparam int c_SW_W      = $clog2(SWRST_PULSE) + 1;

  localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_STABLE_LAST  = c_CNT_W'(STABLE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_STAGGER_LAST = c_CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST     = c_IDX_W'(NUM_PERIPH - 1);
  localparam logic [c_SW_W-1:0]  c_SW_LOAD      = c_SW_W'(SWRST_PULSE);

  logic [LOCK_SYNC_STAGES-1:0] r_ddr_sync;
  logic [LOCK_SYNC_STAGES-1:0] r_tmds_sync;
  logic                        w_locked;

  state_t                r_state;
  logic [c_CNT_W-1:0]    r_cnt;
  logic [c_IDX_W-1:0]    r_idx;
  logic [NUM_PERIPH-1:0] r_periph_rst;
  logic                  r_video_rst;
  logic                  r_mem_clk_en;
  logic                  r_sys_ready;
  logic                  r_lock_lost;
  logic                  r_pll_fault;

  logic [NUM_PERIPH-1:0] r_swrst_q;
  logic [c_SW_W-1:0]     r_swcnt [NUM_PERIPH];
  logic [NUM_PERIPH-1:0] w_rise;
  logic [NUM_PERIPH-1:0] w_pulse;
  logic [NUM_PERIPH-1:0] w_slot;
  logic                  w_lock_loss;

  always_ff @(posedge io_ahb_PCLK or negedge io_ahb_PRESETn) begin
    if (!io_ahb_PRESETn) begin
      r_ddr_sync  <= '0;
      r_tmds_sync <= '0;
    end else begin
      r_ddr_sync  <= {r_ddr_sync[LOCK_SYNC_STAGES-2:0], ddr_pll_lock};
      r_tmds_sync <= {r_tmds_sync[LOCK_SYNC_STAGES-2:0], tmds_pll_lock};
    end
  end

  assign w_locked = r_ddr_sync[LOCK_SYNC_STAGES-1] & r_tmds_sync[LOCK_SYNC_STAGES-1];

  // Only a drop after memory has been enabled counts as a loss; STABLE just retries.
  assign w_lock_loss = ((r_state == ST_MEM_EN) || (r_state == ST_RELEASE) || (r_state == ST_RUN))
                       && !w_locked;

  assign w_rise = periph_swrst & ~r_swrst_q;

  always_comb begin
    w_pulse = '0;
    w_slot  = '0;
    for (int i = 0; i < NUM_PERIPH; i++) begin
      w_pulse[i] = (r_swcnt[i] != '0);
      w_slot[i]  = (r_idx == c_IDX_W'(i));
    end
  end

  always_ff @(posedge io_ahb_PCLK or negedge io_ahb_PRESETn) begin
    if (!io_ahb_PRESETn) begin
      r_swrst_q <= '0;
      for (int i = 0; i < NUM_PERIPH; i++) r_swcnt[i] <= '0;
    end else begin
      r_swrst_q <= periph_swrst;
      for (int i = 0; i < NUM_PERIPH; i++) begin
        if ((r_state != ST_RUN) || !w_locked) r_swcnt[i] <= '0;
        else if (w_rise[i])                   r_swcnt[i] <= c_SW_LOAD;
        else if (r_swcnt[i] != '0)            r_swcnt[i] <= r_swcnt[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge io_ahb_PCLK or negedge io_ahb_PRESETn) begin
    if (!io_ahb_PRESETn) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_periph_rst <= '1;
      r_video_rst  <= 1'b1;
      r_mem_clk_en <= 1'b0;
      r_sys_ready  <= 1'b0;
      r_lock_lost  <= 1'b0;
      r_pll_fault  <= 1'b0;
    end else begin
      if (w_lock_loss)        r_lock_lost <= 1'b1;
      else if (lock_lost_clr) r_lock_lost <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_state <= ST_WAIT_LOCK;
          r_cnt   <= '0;
        end
        ST_WAIT_LOCK: begin
          if (w_locked) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == c_TIMEOUT_LAST) begin
            r_state     <= ST_FAULT;
            r_pll_fault <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_STABLE: begin
          if (!w_locked) begin
            r_state <= ST_WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == c_STABLE_LAST) begin
            r_state <= ST_MEM_EN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_MEM_EN, ST_RELEASE, ST_RUN: begin
          if (w_lock_loss) begin
            r_state      <= ST_WAIT_LOCK;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_periph_rst <= '1;
            r_video_rst  <= 1'b1;
            r_mem_clk_en <= 1'b0;
            r_sys_ready  <= 1'b0;
          end else if (r_state == ST_MEM_EN) begin
            r_mem_clk_en <= 1'b1;
            if (r_cnt == c_STAGGER_LAST) begin
              r_state     <= ST_RELEASE;
              r_cnt       <= '0;
              r_idx       <= '0;
              r_video_rst <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else if (r_state == ST_RELEASE) begin
            // Disabled peripherals still use their slot so the release cadence is fixed.
            if (r_cnt == c_STAGGER_LAST) begin
              r_cnt        <= '0;
              r_periph_rst <= (r_periph_rst & ~w_slot) | (~periph_en & w_slot);
              if (r_idx == c_IDX_LAST) begin
                r_state     <= ST_RUN;
                r_sys_ready <= 1'b1;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_periph_rst <= ~periph_en | w_pulse;
          end
        end
        ST_FAULT: begin
          r_periph_rst <= '1;
          r_video_rst  <= 1'b1;
          r_mem_clk_en <= 1'b0;
          r_sys_ready  <= 1'b0;
          r_pll_fault  <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign memory_clk_en = r_mem_clk_en;
  assign video_rst     = r_video_rst;
  assign periph_rst    = r_periph_rst;
  assign sys_ready     = r_sys_ready;
  assign lock_lost     = r_lock_lost;
  assign pll_fault     = r_pll_fault;
  assign state         = r_state;

endmodule
`default_nettype wire
